// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending FSM.
// Holds the FSM state enum and the price lookup over a packed price table.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_e;

    // Widest packed price table the lookup accepts.
    localparam int TBL_W = 256;

    // Returns the w-bit field idx of a packed table, zero-extended to 32 bits.
    function automatic logic [31:0] price_of(
        input logic [TBL_W-1:0] tbl,
        input int unsigned      idx,
        input int unsigned      w
    );
        logic [TBL_W-1:0] sh;
        logic [TBL_W-1:0] mask;
        sh   = tbl >> (idx * w);
        mask = (TBL_W'(1) << w) - TBL_W'(1);
        return 32'(sh & mask);
    endfunction

endpackage

// File: rtl/vending_fsm_param_if.sv
// Coin/select/status bundle between the pin wrapper and the vending FSM.
// master drives coins, select, cancel (and restock when VEND_STOCK_EN);
// slave returns credit, dispense, prod_out, change_pulse, busy, deny,
// coin_reject (and sold_out when VEND_STOCK_EN).
interface vending_fsm_param_if #(
    parameter int CREDIT_W = 4,
    parameter int COIN_W   = 2,
    parameter int NUM_PROD = 4
);
    localparam int PROD_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

    logic                coin_valid;
    logic [COIN_W-1:0]   coin_val;
    logic                sel_valid;
    logic [PROD_W-1:0]   sel_prod;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [PROD_W-1:0]   prod_out;
    logic                change_pulse;
    logic                busy;
    logic                deny;
    logic                coin_reject;
`ifdef VEND_STOCK_EN
    logic                restock;
    logic [NUM_PROD-1:0] sold_out;
`endif

    modport master (
        output coin_valid, coin_val, sel_valid, sel_prod, cancel,
`ifdef VEND_STOCK_EN
        output restock,
        input  sold_out,
`endif
        input  credit, dispense, prod_out, change_pulse, busy, deny,
               coin_reject
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_prod, cancel,
`ifdef VEND_STOCK_EN
        input  restock,
        output sold_out,
`endif
        output credit, dispense, prod_out, change_pulse, busy, deny,
               coin_reject
    );

endinterface

// File: rtl/vending_stock.sv
// Per-product stock counters, built only when VEND_STOCK_EN is defined.
// Ports: clk, rst, restock_i (refill all), take_i/take_idx_i (one vend),
// sold_out_o (registered, one bit per product with zero stock).
module vending_stock #(
    parameter int NUM_PROD   = 4,
    parameter int STOCK_INIT = 3,
    parameter int PROD_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restock_i,
    input  logic                take_i,
    input  logic [PROD_W-1:0]   take_idx_i,
    output logic [NUM_PROD-1:0] sold_out_o
);
    localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
    localparam logic [STOCK_W-1:0] INIT = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] cnt_q [NUM_PROD];
    logic [STOCK_W-1:0] cnt_d [NUM_PROD];
    logic [NUM_PROD-1:0] sold_q, sold_d;

    // Restock wins over a vend in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            cnt_d[i] = cnt_q[i];
            if (restock_i) begin
                cnt_d[i] = INIT;
            end else if (take_i && (int'(take_idx_i) == i)
                         && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - STOCK_W'(1);
            end
            sold_d[i] = (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                cnt_q[i] <= INIT;
            end
            sold_q <= {NUM_PROD{STOCK_INIT == 0}};
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sold_q <= sold_d;
        end
    end

    assign sold_out_o = sold_q;

endmodule

// File: rtl/vending_fsm_param.sv
// Parametrised vending FSM: multi-value coins, per-product prices, cancel,
// unit-by-unit change. Ports: clk, rst, bus (vending_fsm_param_if.slave).
// Optional stock tracking is enabled by defining VEND_STOCK_EN.
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 4,
    parameter int COIN_W   = 2,
    parameter int NUM_PROD = 4,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_TABLE = 16'h9753
`ifdef VEND_STOCK_EN
    ,
    parameter int STOCK_INIT = 3
`endif
) (
    input logic              clk,
    input logic              rst,
    vending_fsm_param_if.slave bus
);
    localparam int PROD_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic disp_q, disp_d, chg_q, chg_d;
    logic deny_q, deny_d, rej_q, rej_d, busy_q;
    logic accept;

    logic                coin_in;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] price;
    logic                in_range;
    logic                stock_ok;
    logic                sel_ok;

    // A zero coin value is treated as no coin at all.
    assign coin_in  = bus.coin_valid && (bus.coin_val != '0);
    // One extra bit so an overflowing coin is detected, not wrapped.
    assign sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(bus.coin_val);
    assign price    = CREDIT_W'(price_of(TBL_W'(PRICE_TABLE),
                                         32'(bus.sel_prod), CREDIT_W));
    assign in_range = int'(bus.sel_prod) < NUM_PROD;

`ifdef VEND_STOCK_EN
    logic [NUM_PROD-1:0] sold_out;
    assign stock_ok = in_range && !sold_out[bus.sel_prod];

    vending_stock #(
        .NUM_PROD  (NUM_PROD),
        .STOCK_INIT(STOCK_INIT),
        .PROD_W    (PROD_W)
    ) u_stock (
        .clk       (clk),
        .rst       (rst),
        .restock_i (bus.restock),
        .take_i    (accept),
        .take_idx_i(bus.sel_prod),
        .sold_out_o(sold_out)
    );

    assign bus.sold_out = sold_out;
`else
    assign stock_ok = 1'b1;
`endif

    assign sel_ok = in_range && stock_ok && (credit_q >= price);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        prod_d   = prod_q;
        disp_d   = 1'b0;
        deny_d   = 1'b0;
        rej_d    = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cancel) begin
                    rej_d = coin_in;
                    if (credit_q != '0) state_d = CHANGE;
                end else if (bus.sel_valid) begin
                    rej_d = coin_in;
                    if (sel_ok) begin
                        state_d  = DISPENSE;
                        disp_d   = 1'b1;
                        prod_d   = bus.sel_prod;
                        credit_d = credit_q - price;
                        accept   = 1'b1;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (coin_in) begin
                    if (sum > MAX_CREDIT) rej_d = 1'b1;
                    else credit_d = sum[CREDIT_W-1:0];
                end
            end
            DISPENSE: begin
                rej_d   = coin_in;
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // The pulse for this unit is already on the output.
                rej_d    = coin_in;
                credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        chg_d = (state_d == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            prod_q   <= '0;
            disp_q   <= 1'b0;
            chg_q    <= 1'b0;
            deny_q   <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            prod_q   <= prod_d;
            disp_q   <= disp_d;
            chg_q    <= chg_d;
            deny_q   <= deny_d;
            rej_q    <= rej_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.credit       = credit_q;
    assign bus.dispense     = disp_q;
    assign bus.prod_out     = prod_q;
    assign bus.change_pulse = chg_q;
    assign bus.busy         = busy_q;
    assign bus.deny         = deny_q;
    assign bus.coin_reject  = rej_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed scoreboard bench for vending_fsm_param.
// Adds the stock checks when VEND_STOCK_EN is defined.
module tb_vending_fsm_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vending_fsm_param_if #(.CREDIT_W(4), .COIN_W(2), .NUM_PROD(4)) bus ();

    vending_fsm_param #(
        .CREDIT_W   (4),
        .COIN_W     (2),
        .NUM_PROD   (4),
        .PRICE_TABLE(16'h9753)
`ifdef VEND_STOCK_EN
        ,
        .STOCK_INIT (1)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cr       = 0;
    int price[4] = '{3, 5, 7, 9};
    int stock[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty: got %0d want <entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: got %0d want %0d", e.tag, obs, e.val);
        end
    endtask

    task automatic coin(input int v);
        logic rej;
        rej = (v != 0) && (cr + v > 15);
        if (v != 0 && !rej) cr += v;
        bus.coin_valid = 1'b1;
        bus.coin_val   = 2'(v);
        push("coin_credit", 32'(cr));
        push("coin_reject", 32'(rej));
        tick();
        bus.coin_valid = 1'b0;
        chk(32'(bus.credit));
        chk(32'(bus.coin_reject));
    endtask

    // Counts change pulses from a busy sample until busy drops.
    task automatic drain(input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.change_pulse === 1'b1) n++;
            if (bus.busy !== 1'b1) break;
            tick();
        end
        cr = 0;
        push("change_count", 32'(exp_n));
        chk(32'(n));
        push("drain_credit", 0);
        chk(32'(bus.credit));
        push("drain_busy", 0);
        chk(32'(bus.busy));
    endtask

    task automatic buy(input int p, output logic ok);
        ok = (cr >= price[p]) && (stock[p] > 0);
        if (ok) begin
            cr -= price[p];
            stock[p]--;
        end
        bus.sel_valid = 1'b1;
        bus.sel_prod  = 2'(p);
        push("dispense", 32'(ok));
        push("deny", 32'(!ok));
        push("credit_after_sel", 32'(cr));
        if (ok) push("prod_out", 32'(p));
        tick();
        bus.sel_valid = 1'b0;
        chk(32'(bus.dispense));
        chk(32'(bus.deny));
        chk(32'(bus.credit));
        if (ok) chk(32'(bus.prod_out));
    endtask

    initial begin
        logic ok;
        int   n;
        for (int i = 0; i < 4; i++) begin
`ifdef VEND_STOCK_EN
            stock[i] = 1;
`else
            stock[i] = 1000;
`endif
        end
        bus.coin_valid = 1'b0;
        bus.coin_val   = '0;
        bus.sel_valid  = 1'b0;
        bus.sel_prod   = '0;
        bus.cancel     = 1'b0;
`ifdef VEND_STOCK_EN
        bus.restock    = 1'b0;
`endif
        tick();
        tick();
        push("rst_credit", 0);
        push("rst_dispense", 0);
        push("rst_prod", 0);
        push("rst_change", 0);
        push("rst_busy", 0);
        push("rst_deny", 0);
        push("rst_reject", 0);
        chk(32'(bus.credit));
        chk(32'(bus.dispense));
        chk(32'(bus.prod_out));
        chk(32'(bus.change_pulse));
        chk(32'(bus.busy));
        chk(32'(bus.deny));
        chk(32'(bus.coin_reject));
        rst = 1'b0;

        // Buy p0 with 4 credit: one unit of change.
        coin(2);
        coin(2);
        buy(0, ok);
        push("busy_dispense", 1);
        chk(32'(bus.busy));
        drain(1);

        // Insufficient credit.
        coin(2);
        coin(2);
        buy(1, ok);
        tick();
        push("deny_single", 0);
        chk(32'(bus.deny));
        push("credit_kept", 4);
        chk(32'(bus.credit));

        // Overflow boundary.
        coin(3);
        coin(3);
        coin(3);
        coin(1);
        coin(3);
        coin(1);
        coin(1);

        // Cancel at full credit.
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        drain(15);

        // Cancel with zero credit does nothing.
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        push("cancel0_busy", 0);
        chk(32'(bus.busy));
        push("cancel0_change", 0);
        chk(32'(bus.change_pulse));

        // Cancel with a coin in the same cycle.
        coin(3);
        coin(3);
        bus.cancel     = 1'b1;
        bus.coin_valid = 1'b1;
        bus.coin_val   = 2'd2;
        tick();
        bus.cancel     = 1'b0;
        bus.coin_valid = 1'b0;
        push("cancel_coin_reject", 1);
        chk(32'(bus.coin_reject));
        drain(6);

        // Zero-value coin is ignored.
        coin(0);

        // Reset in the middle of change.
        coin(3);
        coin(2);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        push("mid_pulse1", 1);
        chk(32'(bus.change_pulse));
        tick();
        push("mid_pulse2", 1);
        chk(32'(bus.change_pulse));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cr  = 0;
        push("mid_rst_credit", 0);
        push("mid_rst_change", 0);
        push("mid_rst_busy", 0);
        chk(32'(bus.credit));
        chk(32'(bus.change_pulse));
        chk(32'(bus.busy));
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.change_pulse !== 1'b0) n++;
        end
        push("post_rst_pulses", 0);
        chk(32'(n));

        // Exact price, then select and coin while busy.
        coin(3);
        coin(3);
        coin(3);
        buy(3, ok);
        bus.sel_valid  = 1'b1;
        bus.sel_prod   = 2'd0;
        bus.coin_valid = 1'b1;
        bus.coin_val   = 2'd1;
        tick();
        bus.sel_valid  = 1'b0;
        bus.coin_valid = 1'b0;
        push("busy_no_deny", 0);
        push("busy_coin_reject", 1);
        push("busy_no_dispense", 0);
        push("exact_no_change", 0);
        push("exact_idle", 0);
        chk(32'(bus.deny));
        chk(32'(bus.coin_reject));
        chk(32'(bus.dispense));
        chk(32'(bus.change_pulse));
        chk(32'(bus.busy));

`ifdef VEND_STOCK_EN
        push("sold_out_init", 0);
        chk(32'(bus.sold_out[2]));
        coin(3);
        coin(3);
        coin(1);
        buy(2, ok);
        push("sold_out_p2", 1);
        chk(32'(bus.sold_out[2]));
        drain(0);
        coin(3);
        coin(3);
        coin(1);
        buy(2, ok);
        bus.restock = 1'b1;
        tick();
        bus.restock = 1'b0;
        for (int i = 0; i < 4; i++) stock[i] = 1;
        push("restock_clear", 0);
        chk(32'(bus.sold_out));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
Parametrised successor to the single-product coin/accept vending FSM. Supports NUM_PROD products with individual prices, multi-value coins, credit saturation protection, cancel/refund and unit-by-unit change return. Sits behind the Tiny Tapeout top wrapper: pins feed coins and selection in, and dispense/product/credit go out to uo_out. All outputs are registered.

Parameters:
- CREDIT_W, 4, credit register width; MAX_CREDIT = 2^CREDIT_W-1.
- COIN_W, 2, coin value input width; coin value 0 is a no-coin.
- NUM_PROD, 4, number of products; PROD_W = max(1, clog2(NUM_PROD)), derived.
- PRICE_TABLE, 16'h9753, packed NUM_PROD*CREDIT_W prices; product i occupies bits [i*CREDIT_W +: CREDIT_W]. Defaults: p0=3, p1=5, p2=7, p3=9.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin present this cycle.
- coin_val  in  COIN_W  coin value, 1..2^COIN_W-1.
- sel_valid  in  1  purchase request this cycle.
- sel_prod  in  PROD_W  requested product index.
- cancel  in  1  refund request.
- credit  out  CREDIT_W  current credit.
- dispense  out  1  one-cycle vend pulse.
- prod_out  out  PROD_W  product being dispensed; holds its last value otherwise.
- change_pulse  out  1  one pulse per credit unit returned.
- busy  out  1  high in DISPENSE and CHANGE.
- deny  out  1  one-cycle pulse: select refused.
- coin_reject  out  1  one-cycle pulse: coin not accepted, physically returned.

Behaviour:
- Reset (synchronous, any state, including mid-change): state=IDLE; credit=0; dispense=0; prod_out=0; change_pulse=0; busy=0; deny=0; coin_reject=0. Any pending change is discarded and no further pulses occur.
- States: IDLE, DISPENSE, CHANGE.
- IDLE priority order per cycle: cancel > sel_valid > coin_valid.
- IDLE, cancel=1:
  - credit>0: go to CHANGE.
  - credit=0: no effect.
  - A coin or select in the same cycle is ignored; the coin gets coin_reject=1.
- IDLE, sel_valid=1:
  - sel_prod >= NUM_PROD or credit < price: deny=1 next cycle, stay IDLE.
  - Otherwise: next cycle state=DISPENSE, dispense=1, prod_out=sel_prod, credit=credit-price.
  - A coin in the same cycle as a select is rejected (coin_reject=1), whether or not the select is accepted.
- IDLE, coin_valid only:
  - coin_val=0: ignored.
  - credit+coin_val > MAX_CREDIT, computed at CREDIT_W+1 bits with no wrap: coin_reject=1, credit unchanged.
  - Otherwise: credit += coin_val, visible next cycle.
- DISPENSE (exactly 1 cycle): go to CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each cycle: change_pulse=1, credit -= 1.
  - Leaving: when credit would reach 0, the last pulse is issued and the state goes to IDLE.
  - Pulse count equals the credit on entry.
- While busy: sel_valid and cancel are ignored without deny; coins give coin_reject=1.
- Latency: select accepted in cycle N gives dispense in N+1 and the first change_pulse in N+2. Coin in cycle N updates credit in N+1.
- deny, coin_reject and dispense are single-cycle pulses and are never held.

Optional Feature:
VEND_STOCK_EN.
- Defined:
  - Adds parameter STOCK_INIT (default 3) and one STOCK_W-bit counter per product.
  - Adds input restock (refills every counter to STOCK_INIT) and output sold_out[NUM_PROD-1:0], registered.
  - A select of a product with zero stock gives deny. Each dispense decrements that product's counter.
  - Counters reset to STOCK_INIT.
- Undefined: unlimited stock; no restock or sold_out ports.

Decomposition:
- Package vending_pkg: state enum (IDLE, DISPENSE, CHANGE) and a price-extract function over PRICE_TABLE.
- Sub-module vending_stock holds the per-product counters; it is instantiated only under VEND_STOCK_EN.

Test Plan:
- Reset, then coins 2,2 (credit 4), then select p0 (price 3) -> dispense at N+1 with prod_out=0, credit 1, one change_pulse, back to IDLE with credit 0.
- Credit 4, select p1 (price 5) -> deny pulse, credit stays 4, no dispense.
- Credit 14, coin 3 -> coin_reject, credit 14; then coin 1 -> credit 15.
- Credit 6, cancel together with coin 2 -> coin_reject, then 6 consecutive change_pulses, credit 0.
- rst asserted after 2 of 5 change pulses -> credit 0 next cycle, no further pulses, state IDLE.
- VEND_STOCK_EN with STOCK_INIT=1: buy p2 twice with enough credit -> first dispenses and sold_out[2]=1; second gets deny; restock clears sold_out.
